// File: rtl/hs_defs.sv
// ---------------------------------------------------------------------------
// hs_defs -- shared definitions for the 4-phase handshake CDC pair
// (hs_rx destination side, hs_tx source side).
//
// Contents:
//   hs_state_e : three-state handshake FSM encoding (IDLE/HOLD/ACK)
//   HS_WIDTH   : default data bus width
//   HS_CNT_W   : default transfer-counter width
// ---------------------------------------------------------------------------
package hs_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } hs_state_e;

  localparam int HS_WIDTH = 8;
  localparam int HS_CNT_W = 8;

endpackage : hs_defs

// File: rtl/hs_rx.sv
// ---------------------------------------------------------------------------
// hs_rx -- destination side of a 4-phase req/ack clock-domain crossing.
//
// A word held stable by the source is captured when the (externally
// synchronized) request is seen high, presented to a local valid/ready
// consumer, and acknowledged once the consumer takes it. The acknowledge
// stays high until the request is withdrawn.
//
// Ports:
//   clk        in   destination-domain clock (rising edge)
//   rst        in   asynchronous active-high reset
//   req_sync   in   4-phase request, already synchronized to clk
//   data_in    in   [WIDTH]  source data, stable while req is high
//   ack        out  registered 4-phase acknowledge to the source domain
//   out_valid  out  captured word available to the local consumer
//   out_data   out  [WIDTH]  captured word, constant while out_valid=1
//   out_ready  in   local consumer accepts the word
//   xfer_cnt   out  [CNT_W]  completed local handshakes, wraps silently
//   proto_err  out  sticky: request withdrawn before acknowledge
// ---------------------------------------------------------------------------
module hs_rx
  import hs_defs::*;
#(
  parameter int WIDTH = HS_WIDTH,
  parameter int CNT_W = HS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_sync,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err
);

  hs_state_e        state_q, state_d;
  logic             ack_q, ack_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        if (req_sync) begin
          data_d  = data_in;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end

      HOLD: begin
        // A request dropped before we acknowledged is flagged, but the
        // word already captured is still delivered normally.
        if (!req_sync) begin
          err_d = 1'b1;
        end
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = ACK;
        end
      end

      ACK: begin
        if (!req_sync) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        // Unused encoding: fall back to a clean idle.
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ack       = ack_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign xfer_cnt  = cnt_q;
  assign proto_err = err_q;

endmodule : hs_rx
